l2_data_ctrl: RTL and testbench
===============================

L2_DATA_CTRL -- requirements
Module: l2_data_ctrl

Interface
REQ-001 SHALL have parameter WR_STARVE_MAX, default 4: consecutive cycles a write may lose arbitration before it is forced through.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i in 1, rising-edge clock; rst_i in 1, reset.
REQ-003 SHALL have port rd_req_valid_i / rd_req_ready_o, in/out, 1/1: read request handshake.
REQ-004 SHALL have port rd_req_addr_i / rd_req_id_i, in, 9/4: read set index and tag returned with the data.
REQ-005 SHALL have port wr_req_valid_i / wr_req_ready_o, in/out, 1/1: write request handshake.
REQ-006 SHALL have port wr_req_addr_i / wr_req_data_i / wr_req_strob_i, in, 9/256/32: write index, data, byte strobes.
REQ-007 SHALL have port rd_resp_valid_o / rd_resp_ready_i, out/in, 1/1: read response handshake.
REQ-008 SHALL have port rd_resp_data_o / rd_resp_id_o, out, 256/4: read data and echoed id.
REQ-009 SHALL have port ram_cs_o / ram_we_o / ram_addr_o, out, 1/1/9: data-SRAM control.
REQ-010 SHALL have port ram_wdata_o / ram_wdata_strob_o, out, 256/32: SRAM write data and byte strobes.
REQ-011 SHALL have port ram_rdata_i, in, 256: SRAM read data, valid the cycle after a read.

Function
REQ-012 SHALL drive ram_* combinationally from the granted request in the accept cycle; at most one grant per cycle.
REQ-013 SHALL default arbitration to read priority; a write is granted when no read is eligible or its lose-counter reaches WR_STARVE_MAX.
REQ-014 SHALL make a read eligible only when 2-entry response FIFO occupancy plus in-flight reads is below 2.
REQ-015 SHALL capture ram_rdata_i and id into the FIFO one cycle after the read grant (N+1); rd_resp_valid_o rises at N+2; responses stay in issue order.
REQ-016 SHALL hold rd_resp_data_o/rd_resp_id_o stable while valid && !ready.
REQ-017 SHALL accept a write with all-zero strobe but keep ram_cs_o low for it.
REQ-018 SHALL reset the write lose-counter on every write grant, or when wr_req_valid_i is low.
REQ-019 SHALL allow a FIFO pop and capture in the same cycle; a read may be granted that cycle if REQ-014 holds after the pop.
REQ-020 SHALL NOT order requests across channels; a same-address read and write in one cycle returns pre-write data when the read wins.

Reset
REQ-021 SHALL, while rst_i is high, drive ram_cs_o=0, ram_we_o=0, rd_req_ready_o=0, wr_req_ready_o=0, rd_resp_valid_o=0.
REQ-022 SHALL, on reset, clear FIFO, in-flight flag and lose-counter; a read in flight is dropped with no response.
REQ-023 SHALL set rd_resp_data_o and rd_resp_id_o to zero after reset.

Configuration
REQ-024 SHALL, with L2_DATA_PERF_CNT_EN defined, add outputs perf_rd_cnt_o, perf_wr_cnt_o, perf_stall_cnt_o (32 bits each, reset 0, wrapping).
REQ-025 SHALL, with L2_DATA_PERF_CNT_EN defined, count read grants, write grants, and cycles a valid read was blocked by REQ-014.
REQ-026 SHALL, without L2_DATA_PERF_CNT_EN, omit those ports and counters; other behaviour is identical.

Structure
REQ-027 SHALL place L2_DATA_IDX_W=9, L2_DATA_W=256, L2_DATA_STRB_W=32, L2_REQ_ID_W=4 and typedef l2_rd_resp_t (data, id) in package l2_data_pkg.
REQ-028 SHALL implement the response FIFO as sub-module l2_data_resp_fifo (depth 2, valid/ready, synchronous reset).

Verification
REQ-029 SHALL cover: read addr 0x1A5, id 3, at cycle N with resp ready -> ram_cs_o=1, ram_we_o=0 at N; rd_resp_valid_o=1, id 3, at N+2.
REQ-030 SHALL cover: read and write valid continuously, WR_STARVE_MAX=4 -> write granted on 5th cycle, then reads resume.
REQ-031 SHALL cover: rd_resp_ready_i=0, three reads offered -> two accepted, rd_req_ready_o=0 after, perf_stall_cnt_o increments; release ready -> third read issues.
REQ-032 SHALL cover: write strobe 0x00000000 -> wr_req_ready_o=1, ram_cs_o=0; write strobe 0x0000000F -> ram_wdata_strob_o=0x0000000F.
REQ-033 SHALL cover: rst_i asserted the cycle after a read grant -> no rd_resp_valid_o after reset deasserts; FIFO empty.

Source files
------------

// File: rtl/l2_data_pkg.sv
// Shared widths and the read-response record for the L2 data-array controller.
package l2_data_pkg;

   localparam int L2_DATA_IDX_W  = 9;
   localparam int L2_DATA_W      = 256;
   localparam int L2_DATA_STRB_W = 32;
   localparam int L2_REQ_ID_W    = 4;

   typedef struct packed {
      logic [L2_DATA_W-1:0]   data;
      logic [L2_REQ_ID_W-1:0] id;
   } l2_rd_resp_t;

endpackage

// File: rtl/l2_data_if.sv
// Request, response and SRAM bus of the L2 data controller, as one bundle.
// Every channel is valid/ready: a beat moves on a cycle where both are high;
// valid may not depend on ready, and payload is held while valid && !ready.
interface l2_data_if;
   import l2_data_pkg::*;

   logic                      rd_req_valid_i;
   logic                      rd_req_ready_o;
   logic [L2_DATA_IDX_W-1:0]  rd_req_addr_i;
   logic [L2_REQ_ID_W-1:0]    rd_req_id_i;

   logic                      wr_req_valid_i;
   logic                      wr_req_ready_o;
   logic [L2_DATA_IDX_W-1:0]  wr_req_addr_i;
   logic [L2_DATA_W-1:0]      wr_req_data_i;
   logic [L2_DATA_STRB_W-1:0] wr_req_strob_i;

   logic                      rd_resp_valid_o;
   logic                      rd_resp_ready_i;
   logic [L2_DATA_W-1:0]      rd_resp_data_o;
   logic [L2_REQ_ID_W-1:0]    rd_resp_id_o;

   logic                      ram_cs_o;
   logic                      ram_we_o;
   logic [L2_DATA_IDX_W-1:0]  ram_addr_o;
   logic [L2_DATA_W-1:0]      ram_wdata_o;
   logic [L2_DATA_STRB_W-1:0] ram_wdata_strob_o;
   logic [L2_DATA_W-1:0]      ram_rdata_i;

   modport slave (
      input  rd_req_valid_i, rd_req_addr_i, rd_req_id_i,
      output rd_req_ready_o,
      input  wr_req_valid_i, wr_req_addr_i, wr_req_data_i, wr_req_strob_i,
      output wr_req_ready_o,
      output rd_resp_valid_o, rd_resp_data_o, rd_resp_id_o,
      input  rd_resp_ready_i,
      output ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wdata_strob_o,
      input  ram_rdata_i
   );

   modport master (
      output rd_req_valid_i, rd_req_addr_i, rd_req_id_i,
      input  rd_req_ready_o,
      output wr_req_valid_i, wr_req_addr_i, wr_req_data_i, wr_req_strob_i,
      input  wr_req_ready_o,
      input  rd_resp_valid_o, rd_resp_data_o, rd_resp_id_o,
      output rd_resp_ready_i,
      input  ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wdata_strob_o,
      output ram_rdata_i
   );

endinterface

// File: rtl/l2_data_resp_fifo.sv
// Two-entry read-response FIFO; push and pop may happen in the same cycle.
// The producer only pushes when it has reserved a slot, so there is no push ready.
module l2_data_resp_fifo
   import l2_data_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  l2_rd_resp_t push_data,
   output logic        pop_valid,
   input  logic        pop_ready,
   output l2_rd_resp_t pop_data,
   output logic [1:0]  count
);

   l2_rd_resp_t mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count_q;
   logic        pop_fire;

   assign pop_fire  = pop_valid & pop_ready;
   assign pop_valid = (count_q != 2'd0);
   assign pop_data  = mem[rd_ptr];
   assign count     = count_q;

   // Storage is cleared so the response bus reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push_valid) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_fire) begin
            rd_ptr <= ~rd_ptr;
         end
         count_q <= count_q + {1'b0, push_valid} - {1'b0, pop_fire};
      end
   end

endmodule

// File: rtl/l2_data_ctrl.sv
// L2 data-array controller: read/write arbitration onto one SRAM port and an
// in-order read-response path. Define L2_DATA_PERF_CNT_EN to add perf counters.
module l2_data_ctrl
   import l2_data_pkg::*;
#(
   parameter int unsigned WR_STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   l2_data_if.slave    bus
`ifdef L2_DATA_PERF_CNT_EN
   ,
   output logic [31:0] perf_rd_cnt_o,
   output logic [31:0] perf_wr_cnt_o,
   output logic [31:0] perf_stall_cnt_o
`endif
);

   localparam int LOSE_W = (WR_STARVE_MAX < 1) ? 1 : $clog2(WR_STARVE_MAX + 1);

   logic              inflight_q;
   logic [3:0]        id_q;
   logic [LOSE_W-1:0] lose_q;
   logic [1:0]        fifo_count;
   logic [2:0]        occ;
   logic              pop;
   logic              head_valid;
   l2_rd_resp_t       head;
   l2_rd_resp_t       cap;
   logic              rd_elig;
   logic              wr_force;
   logic              rd_gnt;
   logic              wr_gnt;
   logic              wr_en;

   // Reservation counts the entry being popped this cycle as already free.
   assign pop     = head_valid & bus.rd_resp_ready_i;
   assign occ     = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight_q};
   assign rd_elig = (occ < 3'd2);

   assign wr_force = bus.wr_req_valid_i && (lose_q >= LOSE_W'(WR_STARVE_MAX));

   assign bus.rd_req_ready_o = !rst_i && rd_elig && !wr_force;
   assign bus.wr_req_ready_o = !rst_i && (wr_force || !(bus.rd_req_valid_i && rd_elig));

   assign rd_gnt = bus.rd_req_valid_i && bus.rd_req_ready_o;
   assign wr_gnt = bus.wr_req_valid_i && bus.wr_req_ready_o;
   // A write with no byte enabled is accepted but never touches the SRAM.
   assign wr_en  = wr_gnt && (|bus.wr_req_strob_i);

   assign bus.ram_cs_o          = rd_gnt || wr_en;
   assign bus.ram_we_o          = wr_en;
   assign bus.ram_addr_o        = wr_gnt ? bus.wr_req_addr_i : bus.rd_req_addr_i;
   assign bus.ram_wdata_o       = bus.wr_req_data_i;
   assign bus.ram_wdata_strob_o = wr_en ? bus.wr_req_strob_i : '0;

   assign cap.data = bus.ram_rdata_i;
   assign cap.id   = id_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_q <= 1'b0;
         id_q       <= '0;
         lose_q     <= '0;
      end else begin
         inflight_q <= rd_gnt;
         if (rd_gnt) begin
            id_q <= bus.rd_req_id_i;
         end
         if (!bus.wr_req_valid_i || wr_gnt) begin
            lose_q <= '0;
         end else begin
            lose_q <= lose_q + LOSE_W'(1);
         end
      end
   end

   l2_data_resp_fifo u_fifo (
      .clk        (clk_i),
      .rst        (rst_i),
      .push_valid (inflight_q),
      .push_data  (cap),
      .pop_valid  (head_valid),
      .pop_ready  (bus.rd_resp_ready_i),
      .pop_data   (head),
      .count      (fifo_count)
   );

   assign bus.rd_resp_valid_o = !rst_i && head_valid;
   assign bus.rd_resp_data_o  = head.data;
   assign bus.rd_resp_id_o    = head.id;

`ifdef L2_DATA_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_rd_cnt_o    <= '0;
         perf_wr_cnt_o    <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         if (rd_gnt) perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
         if (wr_gnt) perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
         if (bus.rd_req_valid_i && !rd_elig) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_data_ctrl.sv
// Directed bench for l2_data_ctrl: reset, read latency, starvation, FIFO
// back-pressure, zero-strobe writes and reset with a read in flight.
module tb_l2_data_ctrl;
   import l2_data_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   int   n_checks = 0;
   int   n_fail   = 0;

   l2_data_if bus ();

`ifdef L2_DATA_PERF_CNT_EN
   logic [31:0] perf_rd_cnt_o, perf_wr_cnt_o, perf_stall_cnt_o;
`endif

   l2_data_ctrl #(.WR_STARVE_MAX(4)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
`ifdef L2_DATA_PERF_CNT_EN
      ,
      .perf_rd_cnt_o    (perf_rd_cnt_o),
      .perf_wr_cnt_o    (perf_wr_cnt_o),
      .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
   );

   // clock/reset
   always #5 clk_i = ~clk_i;

   function automatic logic [255:0] pat(input logic [8:0] a);
      return {8{23'h5A5A5A, a}};
   endfunction

   // SRAM stand-in: data is a pattern of the index, valid the cycle after a read.
   always @(posedge clk_i) begin
      if (bus.ram_cs_o && !bus.ram_we_o) bus.ram_rdata_i <= pat(bus.ram_addr_o);
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      bus.rd_req_valid_i = 1'b0;
      bus.rd_req_addr_i  = '0;
      bus.rd_req_id_i    = '0;
      bus.wr_req_valid_i = 1'b0;
      bus.wr_req_addr_i  = '0;
      bus.wr_req_data_i  = '0;
      bus.wr_req_strob_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      bus.rd_resp_ready_i = 1'b1;
      bus.ram_rdata_i     = '0;

      // reset: outputs quiet even with requests offered
      tick(); tick();
      bus.rd_req_valid_i = 1'b1;
      bus.wr_req_valid_i = 1'b1;
      bus.wr_req_strob_i = '1;
      #1;
      check("rst_ram_cs", bus.ram_cs_o, 0);
      check("rst_ram_we", bus.ram_we_o, 0);
      check("rst_rd_ready", bus.rd_req_ready_o, 0);
      check("rst_wr_ready", bus.wr_req_ready_o, 0);
      check("rst_resp_valid", bus.rd_resp_valid_o, 0);
      tick();
      rst_i = 1'b0;
      idle_inputs();
      #1;
      check("post_rst_resp_data", bus.rd_resp_data_o, 0);
      check("post_rst_resp_id", bus.rd_resp_id_o, 0);
      check("post_rst_resp_valid", bus.rd_resp_valid_o, 0);

      // read 0x1A5 id 3: SRAM read in the accept cycle, response two cycles later
      tick();
      bus.rd_req_valid_i = 1'b1;
      bus.rd_req_addr_i  = 9'h1A5;
      bus.rd_req_id_i    = 4'd3;
      #1;
      check("t1_rd_ready", bus.rd_req_ready_o, 1);
      check("t1_ram_cs", bus.ram_cs_o, 1);
      check("t1_ram_we", bus.ram_we_o, 0);
      check("t1_ram_addr", bus.ram_addr_o, 9'h1A5);
      tick();
      idle_inputs();
      #1;
      check("t1_n1_valid", bus.rd_resp_valid_o, 0);
      tick();
      #1;
      check("t1_n2_valid", bus.rd_resp_valid_o, 1);
      check("t1_n2_id", bus.rd_resp_id_o, 4'd3);
      check("t1_n2_data", bus.rd_resp_data_o, pat(9'h1A5));
      tick();
      #1;
      check("t1_n3_valid", bus.rd_resp_valid_o, 0);

      // read and write both pending: write forced through on the 5th cycle
      tick();
      bus.rd_req_valid_i = 1'b1;
      bus.rd_req_addr_i  = 9'h010;
      bus.rd_req_id_i    = 4'd1;
      bus.wr_req_valid_i = 1'b1;
      bus.wr_req_addr_i  = 9'h020;
      bus.wr_req_data_i  = {8{32'h12345678}};
      bus.wr_req_strob_i = '1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check($sformatf("t2_c%0d_rd_ready", i), bus.rd_req_ready_o, 1);
         check($sformatf("t2_c%0d_wr_ready", i), bus.wr_req_ready_o, 0);
         check($sformatf("t2_c%0d_ram_we", i), bus.ram_we_o, 0);
         tick();
      end
      #1;
      check("t2_c5_wr_ready", bus.wr_req_ready_o, 1);
      check("t2_c5_rd_ready", bus.rd_req_ready_o, 0);
      check("t2_c5_ram_we", bus.ram_we_o, 1);
      check("t2_c5_ram_addr", bus.ram_addr_o, 9'h020);
      tick();
      #1;
      check("t2_c6_rd_ready", bus.rd_req_ready_o, 1);
      check("t2_c6_wr_ready", bus.wr_req_ready_o, 0);
      check("t2_c6_ram_addr", bus.ram_addr_o, 9'h010);
      tick();
      idle_inputs();
      repeat (4) tick();
      #1;
      check("t2_drained", bus.rd_resp_valid_o, 0);

      // response stalled: two reads fit, the third waits for a pop
      tick();
      bus.rd_resp_ready_i = 1'b0;
      bus.rd_req_valid_i  = 1'b1;
      bus.rd_req_addr_i   = 9'h030;
      bus.rd_req_id_i     = 4'd5;
      #1;
      check("t3_c1_rd_ready", bus.rd_req_ready_o, 1);
      tick();
      bus.rd_req_id_i = 4'd6;
      #1;
      check("t3_c2_rd_ready", bus.rd_req_ready_o, 1);
      tick();
      bus.rd_req_id_i = 4'd7;
      #1;
      check("t3_c3_rd_ready", bus.rd_req_ready_o, 0);
      check("t3_c3_ram_cs", bus.ram_cs_o, 0);
      check("t3_c3_valid", bus.rd_resp_valid_o, 1);
      check("t3_c3_id", bus.rd_resp_id_o, 4'd5);
      tick();
      #1;
      check("t3_c4_rd_ready", bus.rd_req_ready_o, 0);
      check("t3_c4_hold_id", bus.rd_resp_id_o, 4'd5);
      check("t3_c4_hold_data", bus.rd_resp_data_o, pat(9'h030));
      tick();
`ifdef L2_DATA_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt_o, 32'd2);
      check("perf_rd", perf_rd_cnt_o, 32'd8);
      check("perf_wr", perf_wr_cnt_o, 32'd1);
`endif
      bus.rd_resp_ready_i = 1'b1;
      #1;
      check("t3_c5_rd_ready", bus.rd_req_ready_o, 1);
      check("t3_c5_ram_cs", bus.ram_cs_o, 1);
      check("t3_c5_id", bus.rd_resp_id_o, 4'd5);
      tick();
      idle_inputs();
      #1;
      check("t3_c6_valid", bus.rd_resp_valid_o, 1);
      check("t3_c6_id", bus.rd_resp_id_o, 4'd6);
      tick();
      #1;
      check("t3_c7_id", bus.rd_resp_id_o, 4'd7);
      check("t3_c7_data", bus.rd_resp_data_o, pat(9'h030));
      tick();
      #1;
      check("t3_c8_valid", bus.rd_resp_valid_o, 0);

      // writes: zero strobe accepted without SRAM access, partial strobe passed through
      tick();
      bus.wr_req_valid_i = 1'b1;
      bus.wr_req_addr_i  = 9'h040;
      bus.wr_req_data_i  = {8{32'hDEADBEEF}};
      bus.wr_req_strob_i = 32'h0000_0000;
      #1;
      check("t4_z_wr_ready", bus.wr_req_ready_o, 1);
      check("t4_z_ram_cs", bus.ram_cs_o, 0);
      tick();
      bus.wr_req_strob_i = 32'h0000_000F;
      #1;
      check("t4_f_wr_ready", bus.wr_req_ready_o, 1);
      check("t4_f_ram_cs", bus.ram_cs_o, 1);
      check("t4_f_ram_we", bus.ram_we_o, 1);
      check("t4_f_strob", bus.ram_wdata_strob_o, 32'h0000_000F);
      check("t4_f_wdata", bus.ram_wdata_o, {8{32'hDEADBEEF}});
      check("t4_f_addr", bus.ram_addr_o, 9'h040);
      tick();
      idle_inputs();

      // reset right after a read grant drops that read
      tick();
      bus.rd_req_valid_i = 1'b1;
      bus.rd_req_addr_i  = 9'h050;
      bus.rd_req_id_i    = 4'd9;
      #1;
      check("t5_ram_cs", bus.ram_cs_o, 1);
      tick();
      idle_inputs();
      rst_i = 1'b1;
      #1;
      check("t5_rst_valid", bus.rd_resp_valid_o, 0);
      tick();
      rst_i = 1'b0;
      #1;
      check("t5_rel_id", bus.rd_resp_id_o, 0);
      check("t5_rel_data", bus.rd_resp_data_o, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t5_after_%0d_valid", i), bus.rd_resp_valid_o, 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
